// File: rtl/eq_operand_loader_if.sv
// Handshake/bus bundle between a serial operand source and eq_operand_loader.
// The master side drives the serial stream and the acknowledge.
// The slave side is the loader, which returns the assembled operands and status.
interface eq_operand_loader_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             in_valid;
  logic             a_bit;
  logic             b_bit;
  logic             set_ack;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             set;
  logic             busy;
  logic             drop;
  logic             mismatch;

  modport master (
    output start, in_valid, a_bit, b_bit, set_ack,
    input  a_out, b_out, set, busy, drop, mismatch
  );

  modport slave (
    input  start, in_valid, a_bit, b_bit, set_ack,
    output a_out, b_out, set, busy, drop, mismatch
  );
endinterface

// File: rtl/eq_operand_loader.sv
// eq_operand_loader: deserialises two LSB-first operand streams into WIDTH-bit
// words and holds them on a_out/b_out with a 'set' qualifier until the consumer
// acknowledges. All outputs are registered.
// Optional feature macro: EQ_LOADER_EARLY_MISMATCH_EN enables the sticky early
// mismatch flag; without it the mismatch output is a constant 0.
module eq_operand_loader #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  eq_operand_loader_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_base_s;
  logic [WIDTH-1:0] a_sr_r, a_sr_s, a_base_s;
  logic [WIDTH-1:0] b_sr_r, b_sr_s, b_base_s;
  logic [WIDTH-1:0] a_out_r, a_out_s;
  logic [WIDTH-1:0] b_out_r, b_out_s;
  logic             set_r, set_s;
  logic             busy_r, busy_s;
  logic             drop_r, drop_s;
  logic             clear_s;
  logic             accept_s;

  // Next-state, datapath and registered-output values for the loader FSM.
  always_comb begin
    state_s  = state_r;
    a_out_s  = a_out_r;
    b_out_s  = b_out_r;
    drop_s   = 1'b0;
    clear_s  = 1'b0;
    accept_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s  = SHIFT;
          clear_s  = 1'b1;
          accept_s = bus.in_valid;
        end else begin
          drop_s   = bus.in_valid;
        end
      end
      SHIFT: begin
        // A start here restarts the word; a concurrent bit becomes bit0.
        if (bus.start) begin
          clear_s  = 1'b1;
          accept_s = bus.in_valid;
        end else begin
          accept_s = bus.in_valid;
        end
      end
      HOLD: begin
        // start is ignored while holding, even together with set_ack.
        if (bus.set_ack) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
        drop_s = bus.in_valid;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Restart clears the partial word before any concurrent bit is shifted in.
    if (clear_s) begin
      a_base_s   = {WIDTH{1'b0}};
      b_base_s   = {WIDTH{1'b0}};
      cnt_base_s = {CW{1'b0}};
    end else begin
      a_base_s   = a_sr_r;
      b_base_s   = b_sr_r;
      cnt_base_s = cnt_r;
    end

    if (accept_s) begin
      a_sr_s = {bus.a_bit, a_base_s[WIDTH-1:1]};
      b_sr_s = {bus.b_bit, b_base_s[WIDTH-1:1]};
      if (cnt_base_s == CNT_LAST) begin
        state_s = HOLD;
        cnt_s   = {CW{1'b0}};
        a_out_s = a_sr_s;
        b_out_s = b_sr_s;
      end else begin
        cnt_s   = cnt_base_s + CW'(1);
      end
    end else begin
      a_sr_s = a_base_s;
      b_sr_s = b_base_s;
      cnt_s  = cnt_base_s;
    end

    set_s  = (state_s == HOLD);
    busy_s = (state_s != IDLE);
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      a_out_r <= {WIDTH{1'b0}};
      b_out_r <= {WIDTH{1'b0}};
      set_r   <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_sr_r  <= a_sr_s;
      b_sr_r  <= b_sr_s;
      a_out_r <= a_out_s;
      b_out_r <= b_out_s;
      set_r   <= set_s;
      busy_r  <= busy_s;
      drop_r  <= drop_s;
    end
  end

  assign bus.a_out = a_out_r;
  assign bus.b_out = b_out_r;
  assign bus.set   = set_r;
  assign bus.busy  = busy_r;
  assign bus.drop  = drop_r;

`ifdef EQ_LOADER_EARLY_MISMATCH_EN
  logic mismatch_r, mismatch_s;

  // Sticky mismatch: cleared by an accepted start, set by any accepted differing bit pair.
  always_comb begin
    if (clear_s) begin
      mismatch_s = accept_s & (bus.a_bit ^ bus.b_bit);
    end else begin
      mismatch_s = mismatch_r | (accept_s & (bus.a_bit ^ bus.b_bit));
    end
  end

  // Mismatch flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r <= 1'b0;
    end else begin
      mismatch_r <= mismatch_s;
    end
  end

  assign bus.mismatch = mismatch_r;
`else
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_eq_operand_loader.sv
// Self-checking bench for eq_operand_loader (WIDTH=4): directed scenarios plus
// randomized traffic, checked against a queue-based reference model with a
// scoreboard of completed words popped by an independent monitor.
module tb_eq_operand_loader;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mm;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  eq_operand_loader_if #(.WIDTH(W)) bus ();

  eq_operand_loader #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bits gathered so far, phase flags, expected outputs.
  int           aq[$];
  int           bq[$];
  bit           m_active = 1'b0;
  bit           m_hold   = 1'b0;
  bit           m_mm     = 1'b0;
  bit           m_drop   = 1'b0;
  logic [W-1:0] m_aout   = '0;
  logic [W-1:0] m_bout   = '0;
  word_t        sb[$];
  logic         prev_set = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_mm();
`ifdef EQ_LOADER_EARLY_MISMATCH_EN
    return m_mm;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    aq.delete();
    bq.delete();
    m_active = 1'b0;
    m_hold   = 1'b0;
    m_mm     = 1'b0;
    m_drop   = 1'b0;
    m_aout   = '0;
    m_bout   = '0;
  endtask

  // Apply one sampled input set to the reference model.
  task automatic model_step(input logic st, input logic iv, input logic a,
                            input logic b, input logic ack);
    logic [W-1:0] wa, wb;
    word_t e;
    m_drop = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_hold) begin
      if (iv) m_drop = 1'b1;
      if (ack) m_hold = 1'b0;
    end else if (m_active || st) begin
      if (st) begin
        aq.delete();
        bq.delete();
        m_mm = 1'b0;
        m_active = 1'b1;
      end
      if (iv) begin
        aq.push_back(int'(a));
        bq.push_back(int'(b));
        if (a != b) m_mm = 1'b1;
        if (aq.size() == W) begin
          wa = '0;
          wb = '0;
          for (int i = 0; i < W; i++) begin
            wa = wa + (W'(aq[i]) << i);
            wb = wb + (W'(bq[i]) << i);
          end
          m_aout = wa;
          m_bout = wb;
          e.a = wa;
          e.b = wb;
          e.mm = exp_mm();
          sb.push_back(e);
          m_hold = 1'b1;
          m_active = 1'b0;
          aq.delete();
          bq.delete();
        end
      end
    end else if (iv) begin
      m_drop = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, let the DUT sample them, update the model.
  task automatic cyc(input logic st, input logic iv, input logic a,
                     input logic b, input logic ack);
    bus.start    = st;
    bus.in_valid = iv;
    bus.a_bit    = a;
    bus.b_bit    = b;
    bus.set_ack  = ack;
    @(posedge clk);
    model_step(st, iv, a, b, ack);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] aw, input logic [W-1:0] bw);
    cyc(1'b1, 1'b1, aw[0], bw[0], 1'b0);
    for (int i = 1; i < W; i++) cyc(1'b0, 1'b1, aw[i], bw[i], 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_out"}, 32'(bus.a_out), 32'd0);
    chk({tag, "_b_out"}, 32'(bus.b_out), 32'd0);
    chk({tag, "_set"}, 32'(bus.set), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_drop"}, 32'(bus.drop), 32'd0);
    chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'd0);
  endtask

  // Monitor: compare every output against the model and pop the scoreboard on set rise.
  always @(negedge clk) begin
    word_t e;
    chk("set", 32'(bus.set), 32'(m_hold));
    chk("busy", 32'(bus.busy), 32'(m_hold | m_active));
    chk("drop", 32'(bus.drop), 32'(m_drop));
    chk("a_out", 32'(bus.a_out), 32'(m_aout));
    chk("b_out", 32'(bus.b_out), 32'(m_bout));
    chk("mismatch", 32'(bus.mismatch), 32'(exp_mm()));
    if (bus.set === 1'b1 && prev_set !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_set", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_a", 32'(bus.a_out), 32'(e.a));
        chk("sb_b", 32'(bus.b_out), 32'(e.b));
        chk("sb_mm", 32'(bus.mismatch), 32'(e.mm));
      end
    end
    prev_set = bus.set;
  end

  initial begin
    logic st, iv, a, b, ack;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.a_bit = 1'b0;
    bus.b_bit = 1'b0; bus.set_ack = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Plain word 4'hB, then ack.
    send_word(4'hB, 4'hB);
    chk("t1_set", 32'(bus.set), 32'd1);
    chk("t1_a", 32'(bus.a_out), 32'hB);
    chk("t1_b", 32'(bus.b_out), 32'hB);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_set_clr", 32'(bus.set), 32'd0);

    // Same word with in_valid gaps 1,0,1,0,0,1,1.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_no_set_yet", 32'(bus.set), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_a", 32'(bus.a_out), 32'hB);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Two bits, then restart with 4'h6.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(4'h6, 4'h6);
    chk("t3_a", 32'(bus.a_out), 32'h6);

    // in_valid during HOLD: drop pulse, outputs frozen; start ignored; start+ack -> IDLE.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_drop", 32'(bus.drop), 32'd1);
    chk("t4_a", 32'(bus.a_out), 32'h6);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_drop_end", 32'(bus.drop), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // Reset after 3 bits.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("t5");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_set_after", 32'(bus.set), 32'd0);

    // Mismatching operands 5 vs 4, then a clean restart.
    send_word(4'h5, 4'h4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'h3, 4'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      st  = ($urandom_range(7) == 0);
      iv  = ($urandom_range(1) == 1);
      a   = 1'($urandom_range(1));
      b   = ($urandom_range(1) == 1) ? a : 1'($urandom_range(1));
      ack = ($urandom_range(2) == 0);
      cyc(st, iv, a, b, ack);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
